// File: rtl/mux2x1_4bits_rr.sv
// Two-source round-robin merge onto one registered, tagged output channel.
// Per-source saturating accept counters are exposed for debug.
module mux2x1_4bits_rr #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_sel;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_space;
  logic w_gnt_vld;
  logic w_gnt;
  logic w_acc0;
  logic w_acc1;

  // Register can take a new word in the same cycle it drains.
  assign w_space = (r_state == EMPTY) || out_ready;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = 1'b0;
    case ({in1_valid, in0_valid})
      2'b01: begin
        w_gnt_vld = 1'b1;
        w_gnt     = 1'b0;
      end
      2'b10: begin
        w_gnt_vld = 1'b1;
        w_gnt     = 1'b1;
      end
      2'b11: begin
        w_gnt_vld = 1'b1;
        w_gnt     = ~r_last;
      end
      default: begin
        w_gnt_vld = 1'b0;
        w_gnt     = 1'b0;
      end
    endcase
  end

  assign w_acc0 = w_space && w_gnt_vld && !w_gnt;
  assign w_acc1 = w_space && w_gnt_vld && w_gnt;

  assign in0_ready = w_acc0;
  assign in1_ready = w_acc1;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = (r_state == FULL);
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;

  // r_last resets to 1 so the first tie goes to source 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      if (w_acc0 || w_acc1) begin
        r_state <= FULL;
        r_data  <= w_acc1 ? in1_data : in0_data;
        r_sel   <= w_acc1;
        r_last  <= w_acc1;
      end else if (out_ready) begin
        r_state <= EMPTY;
      end
      if (w_acc0 && (r_cnt0 != {CNT_W{1'b1}})) begin
        r_cnt0 <= r_cnt0 + 1'b1;
      end
      if (w_acc1 && (r_cnt1 != {CNT_W{1'b1}})) begin
        r_cnt1 <= r_cnt1 + 1'b1;
      end
    end
  end

endmodule
